// File: rtl/adder_client.sv
// AXI-Stream client feeding operand packets into the adder's AXIS slave port.
// Local logic pushes {tlast, tdata} words into an operand FIFO. A single registered
// output stage drains the FIFO with full backpressure, one beat per cycle sustained.

`ifndef DATAW
`define DATAW 32
`endif
`ifndef AXIS_MAX_DATAW
`define AXIS_MAX_DATAW 64
`endif

module adder_client #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNTW       = 16
) (
  input  logic                       clk,
  input  logic                       rst,

  // Local push interface
  input  logic [`DATAW-1:0]          client_tdata,
  input  logic                       client_tlast,
  input  logic                       client_valid,
  output logic                       client_ready,

  // AXIS master towards the adder
  output logic                       axis_client_tvalid,
  output logic                       axis_client_tlast,
  output logic [`AXIS_MAX_DATAW-1:0] axis_client_tdata,
  input  logic                       axis_client_tready,

  // Status
  output logic [CNTW-1:0]            words_sent,
  output logic [CNTW-1:0]            packets_sent,
  output logic                       busy
);

  localparam int unsigned DataW = `DATAW;
  localparam int unsigned AxisW = `AXIS_MAX_DATAW;
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FillW = PtrW + 1;

  localparam logic [FillW-1:0] FillMax = FillW'(FIFO_DEPTH);
  localparam logic [FillW-1:0] FillOne = FillW'(1);
  localparam logic [PtrW-1:0]  PtrOne  = PtrW'(1);
  localparam logic [CNTW-1:0]  CntOne  = CNTW'(1);

  typedef enum logic [0:0] {
    StEmpty,
    StFull
  } state_e;

  typedef struct packed {
    logic             last;
    logic [DataW-1:0] data;
  } entry_t;

  // FIFO storage and bookkeeping
  entry_t           mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FillW-1:0] fill_q, fill_d;

  // Output stage
  state_e           state_q, state_d;
  entry_t           out_q, out_d;

  // Counters and packet tracking
  logic [CNTW-1:0]  words_q, words_d;
  logic [CNTW-1:0]  pkts_q, pkts_d;
  logic             in_pkt_q, in_pkt_d;

  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             beat;

  // Ready comes only from registered fill, so a full FIFO refuses even when popping.
  assign client_ready = rst && (fill_q != FillMax);
  assign push         = client_valid && client_ready;
  assign fifo_empty   = (fill_q == '0);
  assign beat         = (state_q == StFull) && axis_client_tready;

  // Operand storage; contents are don't-care while empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{last: client_tlast, data: client_tdata};
    end
  end

  // Output stage FSM: load a new head whenever the register is empty or being consumed.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    pop     = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (!fifo_empty) begin
          out_d   = mem_q[rd_ptr_q];
          pop     = 1'b1;
          state_d = StFull;
        end
      end
      StFull: begin
        if (axis_client_tready) begin
          if (!fifo_empty) begin
            out_d = mem_q[rd_ptr_q];
            pop   = 1'b1;
          end else begin
            state_d = StEmpty;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // FIFO pointer and fill update; pointers wrap naturally as depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    if (push && !pop) begin
      fill_d = fill_q + FillOne;
    end else if (!push && pop) begin
      fill_d = fill_q - FillOne;
    end
  end

  // Beat counters (free-running wrap) and in-packet tracking.
  always_comb begin
    words_d  = words_q;
    pkts_d   = pkts_q;
    in_pkt_d = in_pkt_q;
    if (beat) begin
      words_d  = words_q + CntOne;
      in_pkt_d = !out_q.last;
      if (out_q.last) begin
        pkts_d = pkts_q + CntOne;
      end
    end
  end

  // State registers; reset clears everything immediately, discarding queued words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      state_q  <= StEmpty;
      out_q    <= '0;
      words_q  <= '0;
      pkts_q   <= '0;
      in_pkt_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      state_q  <= state_d;
      out_q    <= out_d;
      words_q  <= words_d;
      pkts_q   <= pkts_d;
      in_pkt_q <= in_pkt_d;
    end
  end

  // AXIS outputs; operand is zero-extended into the wider bus.
  always_comb begin
    axis_client_tdata              = '0;
    axis_client_tdata[DataW-1:0]   = out_q.data;
    axis_client_tvalid             = (state_q == StFull);
    axis_client_tlast              = out_q.last;
  end

  assign words_sent   = words_q;
  assign packets_sent = pkts_q;
  assign busy         = in_pkt_q || axis_client_tvalid || !fifo_empty;

  // Keep the unused-width relationship explicit for readers of narrower configs.
  logic unused_axis_w;
  assign unused_axis_w = (AxisW >= DataW);

endmodule

// File: doc/adder_client.md
Name: adder_client

Overview:
- AXI-Stream transmitter that feeds operand packets into the adder's AXIS slave port (axis_adder_*).
- Local logic pushes operand words into an internal FIFO. Each pushed word carries a packet-end flag.
- The block drains the FIFO through a registered AXIS master output with full backpressure support.
- Sits in the rtl_add example beside the adder; data widths come from static_params.vh (`DATAW, `AXIS_MAX_DATAW).

Parameters:
- FIFO_DEPTH, 16: operand FIFO entries; power of two, >= 2.
- CNTW, 16: width of the words_sent and packets_sent counters.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  reset, asynchronous, active-low (0 = in reset).
- client_tdata  input  `DATAW  operand word to send.
- client_tlast  input  1  marks the final operand of a packet.
- client_valid  input  1  push request.
- client_ready  output  1  FIFO can accept a word this cycle.
- axis_client_tvalid  output  1  AXIS master valid.
- axis_client_tlast  output  1  AXIS master last.
- axis_client_tdata  output  `AXIS_MAX_DATAW  AXIS master data.
- axis_client_tready  input  1  AXIS slave ready (from the adder).
- words_sent  output  CNTW  count of AXIS beats accepted.
- packets_sent  output  CNTW  count of AXIS beats accepted with tlast=1.
- busy  output  1  work outstanding.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO emptied; pointers and count cleared.
  - axis_client_tvalid, axis_client_tlast, axis_client_tdata, words_sent, packets_sent all 0.
  - busy=0 and client_ready=0 while rst=0; client_ready=1 from the first cycle after deassertion.
  - Outputs clear immediately on assertion, not at the next edge.
  - A mid-packet reset discards all queued words; nothing is replayed.
- Push side:
  - A write occurs on a posedge with client_valid && client_ready.
  - Each entry stores {client_tlast, client_tdata}.
  - client_ready = rst && (fifo_count != FIFO_DEPTH), combinational from registered count.
  - A full FIFO deasserts client_ready even if a pop occurs in the same cycle (no write-through).
  - client_valid while client_ready=0 is ignored; no word is lost or stored.
- Output stage:
  - Single register holding tvalid/tlast/tdata.
  - Total storage = FIFO_DEPTH + 1 words.
- Output stage FSM, state EMPTY: tvalid=0.
  - If the FIFO is non-empty, load the head, pop, and go to FULL.
- Output stage FSM, state FULL: tvalid=1.
  - If tready=1 and FIFO non-empty: load the next head and pop (back-to-back, one beat/cycle); stay FULL.
  - If tready=1 and FIFO empty: go to EMPTY.
  - If tready=0: hold tdata and tlast bit-stable; no pop.
- Data formatting: axis_client_tdata[`DATAW-1:0] = operand; upper bits are zero.
- Latency: a word pushed on edge k with the FIFO and output stage empty gives tvalid=1 after edge k+1.
- Throughput: sustained 1 beat/cycle with client_valid and tready both held high.
- Simultaneous push and pop on a non-full FIFO: count unchanged, both take effect.
- Pointers wrap modulo FIFO_DEPTH.
- Counters:
  - On each tvalid && tready, words_sent increments; packets_sent also increments if tlast=1.
  - Both wrap modulo 2^CNTW without saturation.
- Packet tracking:
  - Internal flag in_pkt sets on an accepted beat with tlast=0 and clears on an accepted beat with tlast=1.
  - busy = in_pkt || tvalid || fifo_count != 0.
- No protocol checking of packet structure: a packet of one word (tlast on first) is legal; a packet with no tlast streams indefinitely.

Test Plan:
1. Push 1,2,3,4 (tlast on 4) with tready=1 -> four consecutive beats 1,2,3,4; tlast only on the 4th; tdata upper bits 0; words_sent=4, packets_sent=1; busy falls the cycle after the last beat.
2. Stream 10,20,30 (tlast on 30) with tready forced 0 for 5 cycles while 20 is presented -> tdata=20, tlast=0 held stable throughout; beats resume 20,30 with no loss or duplication.
3. FIFO_DEPTH=16, tready=0, client_valid held high with values 0..19 -> exactly 17 words accepted, client_ready low from then on; after tready=1, beats 0..16 in order, and client_ready reasserts one cycle after the first pop.
4. FIFO full, tready=1 and client_valid=1 on the same cycle -> pop occurs, push refused that cycle, accepted next cycle; ordering preserved.
5. Assert rst between edges mid-packet (2 of 5 words sent) -> tvalid, counters, and busy go 0 immediately; after release with no pushes, tvalid stays 0.
6. CNTW=4, send 17 single-word packets -> words_sent=1, packets_sent=1 (wrapped).
